ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Memory-side responder for the fetcher's byte-serial RAM interface.
- Each cycle it serves one byte access: a read or a write.
  - Byte-addressed RAM below the IO base.
  - Memory-mapped IO at and above the IO base: a UART TX FIFO, an RX holding register, a status byte and a halt register.
- Sits between the fetcher and the board/simulation top. It provides the fetcher's data_from_ram, with read data available one cycle after the address is presented.

Parameters:
RamAddrWidth, 17, log2 of RAM size in bytes (128 KiB)
IoBase, 32'h0003_0000, first IO address; any address >= IoBase is IO
TxDepth, 8, TX FIFO entries (power of two)
TxPtrWidth, 3, log2(TxDepth)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
is_valid_from_fc  in  1  access request this cycle
is_store_from_fc  in  1  1=write byte, 0=read byte
addr_from_fc  in  32  byte address
data_from_fc  in  8  write byte
data_to_fc  out  8  read byte, registered
is_stall_to_fc  out  1  TX FIFO full
io_tx_data  out  8  UART TX byte (FIFO head)
io_tx_valid  out  1  FIFO non-empty
io_tx_ready  in  1  UART consumes head when valid&ready
io_rx_data  in  8  UART RX byte
io_rx_valid  in  1  RX byte offered
io_rx_ready  out  1  RX holding register empty
is_halt  out  1  sticky; program wrote halt register

Behaviour:
- Reset (rst=0, async): the following all go to 0:
  - data_to_fc, is_stall_to_fc, io_tx_valid, is_halt
  - TX pointers/count, overflow flag, rx_full
  - io_rx_ready goes to 1.
  - RAM contents are not reset.
  - Reset mid-transfer drops any queued TX bytes and any held RX byte.
- Access sampling: on each rising edge with is_valid_from_fc=1. Region select: addr_from_fc < IoBase is RAM, else IO.
- RAM read: data_to_fc <= ram[addr[RamAddrWidth-1:0]]. Latency is 1: address sampled at edge N, data stable from edge N until edge N+1 is sampled by the fetcher.
- RAM write: ram[addr] <= data_from_fc at the edge. data_to_fc holds its previous value.
- Read-during-write to the same address cannot occur, because there is one access per cycle.
- RAM addresses above 2^RamAddrWidth wrap: upper bits are ignored.
- IO decode on addr - IoBase:
  - offset 0, write: push the byte to the TX FIFO.
  - offset 0, read: return the RX byte if rx_full, else 8'h00. Clears rx_full.
  - offset 4, write: set is_halt (sticky until reset). Data is ignored.
  - offset 4, read: return status {5'b0, overflow, rx_full, tx_full}.
  - Other IO offsets: reads return 8'h00; writes are ignored.
- TX FIFO:
  - Push is accepted if count<TxDepth, or if count==TxDepth and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and the sticky overflow flag is set. overflow is cleared only by reset.
  - Pop when io_tx_valid & io_tx_ready.
  - Pointers wrap modulo TxDepth.
  - count updates by +1, -1 or 0 for simultaneous push+pop.
  - is_stall_to_fc = (count==TxDepth), registered.
- io_tx_data/io_tx_valid come from the registered head; no combinational path from the inputs.
- RX:
  - When io_rx_ready & io_rx_valid, latch io_rx_data and set rx_full.
  - io_rx_ready = !rx_full.
  - If an offset-0 read and an RX load happen in the same edge: the read returns the old byte, and the new byte is loaded (rx_full stays 1).
- After is_halt=1: accesses are still serviced, and the TX FIFO keeps draining.
- data_to_fc is not updated on write cycles or idle cycles.

Decomposition:
- Shared package/header: IoBase, IO offsets (IO_UART=0, IO_CTRL=4), status bit positions, byte width constant.
- Sub-module ram_tx_fifo:
  - Parameters: TxDepth, TxPtrWidth.
  - Ports: push/data/full, pop/data/valid, count.
  - Instantiated once.
- RAM array, decode and RX register live in the top.

Test Plan:
- Write 8'hA5 to 0x00010, then read 0x00010 on the next cycle -> data_to_fc==8'hA5 one cycle after the read is sampled. An intervening idle cycle leaves data_to_fc unchanged.
- Write 0x41,0x42,0x43 to 0x30000 with io_tx_ready=0 -> io_tx_valid=1, io_tx_data=0x41. Raise ready for 3 cycles -> bytes 0x41,0x42,0x43 pop in order, then io_tx_valid=0.
- With ready=0, push 9 bytes -> is_stall_to_fc=1 after the 8th. The 9th is dropped; a status read at 0x30004 returns 8'h05.
- With FIFO full, push and pop in the same cycle -> count stays 8, the new byte is kept, overflow stays 0.
- Offer rx byte 0x7E -> io_rx_ready=0. Read 0x30000 while offering 0x7F in the same cycle -> returns 0x7E, rx_full remains, and the next read returns 0x7F.
- Write 0x30004 -> is_halt=1 sticky. Assert rst=0 mid-drain with 3 bytes queued -> io_tx_valid, is_halt and data_to_fc go to 0 immediately; RAM byte at 0x00010 is still 8'hA5 after reset.

Source files
------------

// File: rtl/ram_responder_pkg.sv
// Shared constants and request bundle for the fetcher-side RAM/IO responder.
package ram_responder_pkg;
   localparam int          BYTE_W        = 8;
   localparam logic [31:0] IO_BASE       = 32'h0003_0000;
   localparam logic [31:0] IO_UART       = 32'd0;
   localparam logic [31:0] IO_CTRL       = 32'd4;
   localparam int          STAT_TX_FULL  = 0;
   localparam int          STAT_RX_FULL  = 1;
   localparam int          STAT_OVERFLOW = 2;

   typedef struct packed {
      logic              valid;
      logic              is_store;
      logic [31:0]       addr;
      logic [BYTE_W-1:0] data;
   } fc_req_t;
endpackage

// File: rtl/ram_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; head is read straight from registers.
module ram_tx_fifo
   import ram_responder_pkg::*;
#(
   parameter int TxDepth    = 8,
   parameter int TxPtrWidth = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [BYTE_W-1:0]   push_data,
   output logic                full,
   input  logic                pop,
   output logic [BYTE_W-1:0]   pop_data,
   output logic                pop_valid,
   output logic [TxPtrWidth:0] count
);
   localparam logic [TxPtrWidth:0] CNT_FULL = (TxPtrWidth+1)'(TxDepth);

   logic [TxDepth-1:0][BYTE_W-1:0] mem;
   logic [TxPtrWidth-1:0]          wr_ptr, rd_ptr;
   logic                           do_push, do_pop;

   assign full      = (count == CNT_FULL);
   assign pop_valid = (count != '0);
   assign pop_data  = mem[rd_ptr];
   assign do_pop    = pop & pop_valid;
   // a full FIFO still takes a byte when the head leaves on the same edge
   assign do_push   = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/ram_responder.sv
// Byte-serial RAM plus memory-mapped UART/status/halt registers for the fetcher.
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int          RamAddrWidth = 17,
   parameter logic [31:0] IoBase       = IO_BASE,
   parameter int          TxDepth      = 8,
   parameter int          TxPtrWidth   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              is_valid_from_fc,
   input  logic              is_store_from_fc,
   input  logic [31:0]       addr_from_fc,
   input  logic [BYTE_W-1:0] data_from_fc,
   output logic [BYTE_W-1:0] data_to_fc,
   output logic              is_stall_to_fc,
   output logic [BYTE_W-1:0] io_tx_data,
   output logic              io_tx_valid,
   input  logic              io_tx_ready,
   input  logic [BYTE_W-1:0] io_rx_data,
   input  logic              io_rx_valid,
   output logic              io_rx_ready,
   output logic              is_halt
);
   localparam logic [TxPtrWidth:0] CNT_FULL = (TxPtrWidth+1)'(TxDepth);

   fc_req_t                 req;
   logic [BYTE_W-1:0]       ram [0:(1<<RamAddrWidth)-1];
   logic [RamAddrWidth-1:0] ram_idx;
   logic [31:0]             io_off;
   logic                    is_io, rd, wr;
   logic                    uart_rd, uart_wr, ctrl_rd, ctrl_wr;
   logic                    rx_full, rx_load, overflow, tx_full;
   logic [BYTE_W-1:0]       rx_data, status, rd_byte;
   logic [TxPtrWidth:0]     tx_count;

   assign req     = '{valid: is_valid_from_fc, is_store: is_store_from_fc,
                      addr: addr_from_fc, data: data_from_fc};
   assign is_io   = (req.addr >= IoBase);
   assign io_off  = req.addr - IoBase;
   assign ram_idx = req.addr[RamAddrWidth-1:0];
   assign rd      = req.valid & ~req.is_store;
   assign wr      = req.valid &  req.is_store;
   assign uart_rd = rd & is_io & (io_off == IO_UART);
   assign uart_wr = wr & is_io & (io_off == IO_UART);
   assign ctrl_rd = rd & is_io & (io_off == IO_CTRL);
   assign ctrl_wr = wr & is_io & (io_off == IO_CTRL);

   assign io_rx_ready    = ~rx_full;
   assign rx_load        = io_rx_valid & ~rx_full;
   assign is_stall_to_fc = tx_full;

   always_comb begin
      status                = '0;
      status[STAT_TX_FULL]  = tx_full;
      status[STAT_RX_FULL]  = rx_full;
      status[STAT_OVERFLOW] = overflow;
   end

   always_comb begin
      rd_byte = '0;
      if (!is_io)       rd_byte = ram[ram_idx];
      else if (uart_rd) rd_byte = rx_full ? rx_data : '0;
      else if (ctrl_rd) rd_byte = status;
   end

   always_ff @(posedge clk) begin
      if (wr && !is_io) ram[ram_idx] <= req.data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_to_fc <= '0;
         rx_full    <= 1'b0;
         rx_data    <= '0;
         overflow   <= 1'b0;
         is_halt    <= 1'b0;
      end else begin
         if (rd) data_to_fc <= rd_byte;
         // a load on the same edge as a UART read wins: old byte out, new byte held
         if (rx_load) begin
            rx_data <= io_rx_data;
            rx_full <= 1'b1;
         end else if (uart_rd) begin
            rx_full <= 1'b0;
         end
         if (ctrl_wr) is_halt <= 1'b1;
         if (uart_wr && tx_count == CNT_FULL && !(io_tx_valid && io_tx_ready))
            overflow <= 1'b1;
      end
   end

   ram_tx_fifo #(.TxDepth(TxDepth), .TxPtrWidth(TxPtrWidth)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (uart_wr),
      .push_data (req.data),
      .full      (tx_full),
      .pop       (io_tx_ready),
      .pop_data  (io_tx_data),
      .pop_valid (io_tx_valid),
      .count     (tx_count)
   );
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: table-driven RAM/IO accesses plus TX/RX/halt/reset sequences.
module tb_ram_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        is_valid_from_fc, is_store_from_fc;
   logic [31:0] addr_from_fc;
   logic [7:0]  data_from_fc, data_to_fc;
   logic        is_stall_to_fc;
   logic [7:0]  io_tx_data, io_rx_data;
   logic        io_tx_valid, io_tx_ready, io_rx_valid, io_rx_ready, is_halt;

   int total = 0;
   int bad   = 0;

   ram_responder dut (
      .clk              (clk),
      .rst              (rst),
      .is_valid_from_fc (is_valid_from_fc),
      .is_store_from_fc (is_store_from_fc),
      .addr_from_fc     (addr_from_fc),
      .data_from_fc     (data_from_fc),
      .data_to_fc       (data_to_fc),
      .is_stall_to_fc   (is_stall_to_fc),
      .io_tx_data       (io_tx_data),
      .io_tx_valid      (io_tx_valid),
      .io_tx_ready      (io_tx_ready),
      .io_rx_data       (io_rx_data),
      .io_rx_valid      (io_rx_valid),
      .io_rx_ready      (io_rx_ready),
      .is_halt          (is_halt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        store;
      logic [31:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic v, input logic s, input logic [31:0] a,
                               input logic [7:0] d, input logic [7:0] e);
      vec_t t;
      t.valid = v; t.store = s; t.addr = a; t.wdata = d; t.exp = e;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // one clock; outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic acc(input logic s, input logic [31:0] a, input logic [7:0] d);
      is_valid_from_fc = 1'b1;
      is_store_from_fc = s;
      addr_from_fc     = a;
      data_from_fc     = d;
      step();
      is_valid_from_fc = 1'b0;
      is_store_from_fc = 1'b0;
   endtask

   logic [7:0] drain_exp [8];

   initial begin
      rst = 1'b0;
      is_valid_from_fc = 1'b0; is_store_from_fc = 1'b0;
      addr_from_fc = '0; data_from_fc = '0;
      io_tx_ready = 1'b0; io_rx_valid = 1'b0; io_rx_data = '0;

      vecs[0]  = mk(1, 1, 32'h0001_0, 8'hA5, 8'h00);
      vecs[1]  = mk(1, 0, 32'h0001_0, 8'h00, 8'hA5);
      vecs[2]  = mk(0, 0, 32'h0000_0, 8'h00, 8'hA5);
      vecs[3]  = mk(1, 1, 32'h0001_1, 8'h5A, 8'hA5);
      vecs[4]  = mk(1, 0, 32'h0001_1, 8'h00, 8'h5A);
      vecs[5]  = mk(1, 1, 32'h0002_0020, 8'h3C, 8'h5A);
      vecs[6]  = mk(1, 0, 32'h0000_0020, 8'h00, 8'h3C);
      vecs[7]  = mk(1, 1, 32'h0002_FFFF, 8'h77, 8'h3C);
      vecs[8]  = mk(1, 0, 32'h0000_FFFF, 8'h00, 8'h77);
      vecs[9]  = mk(1, 0, 32'h0003_0008, 8'h00, 8'h00);
      vecs[10] = mk(1, 0, 32'h0001_0, 8'h00, 8'hA5);
      vecs[11] = mk(1, 1, 32'h0003_0008, 8'hFF, 8'hA5);
      vecs[12] = mk(1, 0, 32'h0003_0004, 8'h00, 8'h00);
      vecs[13] = mk(1, 0, 32'h0003_0000, 8'h00, 8'h00);

      #12;
      check("rst data_to_fc", data_to_fc, 0);
      check("rst stall", is_stall_to_fc, 0);
      check("rst tx_valid", io_tx_valid, 0);
      check("rst halt", is_halt, 0);
      check("rst rx_ready", io_rx_ready, 1);
      @(posedge clk); #1; rst = 1'b1;

      foreach (vecs[i]) begin
         is_valid_from_fc = vecs[i].valid;
         is_store_from_fc = vecs[i].store;
         addr_from_fc     = vecs[i].addr;
         data_from_fc     = vecs[i].wdata;
         step();
         check($sformatf("vec%0d data_to_fc", i), data_to_fc, vecs[i].exp);
      end
      is_valid_from_fc = 1'b0; is_store_from_fc = 1'b0;

      // TX ordering
      acc(1, 32'h3_0000, 8'h41);
      check("tx valid after push", io_tx_valid, 1);
      check("tx head", io_tx_data, 8'h41);
      acc(1, 32'h3_0000, 8'h42);
      acc(1, 32'h3_0000, 8'h43);
      io_tx_ready = 1'b1;
      check("tx pop0", io_tx_data, 8'h41);
      step();
      check("tx pop1", io_tx_data, 8'h42);
      step();
      check("tx pop2", io_tx_data, 8'h43);
      step();
      check("tx empty", io_tx_valid, 0);
      io_tx_ready = 1'b0;

      // fill, push+pop while full, then overflow
      for (int i = 0; i < 8; i++) begin
         acc(1, 32'h3_0000, 8'h10 + 8'(i));
         if (i == 6) check("stall before full", is_stall_to_fc, 0);
      end
      check("stall at full", is_stall_to_fc, 1);
      acc(0, 32'h3_0004, 8'h00);
      check("status full", data_to_fc, 8'h01);
      io_tx_ready = 1'b1;
      acc(1, 32'h3_0000, 8'h99);
      io_tx_ready = 1'b0;
      check("stall after push+pop", is_stall_to_fc, 1);
      acc(0, 32'h3_0004, 8'h00);
      check("status no ovf", data_to_fc, 8'h01);
      acc(1, 32'h3_0000, 8'h9A);
      acc(0, 32'h3_0004, 8'h00);
      check("status ovf", data_to_fc, 8'h05);
      for (int i = 0; i < 7; i++) drain_exp[i] = 8'h11 + 8'(i);
      drain_exp[7] = 8'h99;
      io_tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain%0d", i), io_tx_data, drain_exp[i]);
         step();
      end
      check("drained", io_tx_valid, 0);
      io_tx_ready = 1'b0;

      // RX: hold, read while next byte offered
      io_rx_valid = 1'b1; io_rx_data = 8'h7E;
      step();
      io_rx_valid = 1'b0;
      check("rx full ready", io_rx_ready, 0);
      io_rx_valid = 1'b1; io_rx_data = 8'h7F;
      acc(0, 32'h3_0000, 8'h00);
      check("rx read old", data_to_fc, 8'h7E);
      step();
      io_rx_valid = 1'b0;
      check("rx reload", io_rx_ready, 0);
      acc(0, 32'h3_0000, 8'h00);
      check("rx read new", data_to_fc, 8'h7F);
      check("rx empty ready", io_rx_ready, 1);
      // empty register: read and load on the same edge
      io_rx_valid = 1'b1; io_rx_data = 8'h55;
      acc(0, 32'h3_0000, 8'h00);
      io_rx_valid = 1'b0;
      check("rx same-edge read", data_to_fc, 8'h00);
      check("rx same-edge load", io_rx_ready, 0);
      acc(0, 32'h3_0004, 8'h00);
      check("status rx+ovf", data_to_fc, 8'h06);
      acc(0, 32'h3_0000, 8'h00);
      check("rx same-edge byte", data_to_fc, 8'h55);

      // halt, then reset mid-drain
      acc(1, 32'h3_0004, 8'h00);
      check("halt set", is_halt, 1);
      step();
      check("halt sticky", is_halt, 1);
      acc(1, 32'h3_0000, 8'h61);
      acc(1, 32'h3_0000, 8'h62);
      acc(1, 32'h3_0000, 8'h63);
      acc(1, 32'h3_0000, 8'h64);
      acc(0, 32'h0001_1, 8'h00);
      check("pre-rst read", data_to_fc, 8'h5A);
      io_tx_ready = 1'b1;
      step();
      check("draining after halt", io_tx_data, 8'h62);
      #2 rst = 1'b0;
      #1;
      check("arst tx_valid", io_tx_valid, 0);
      check("arst halt", is_halt, 0);
      check("arst data_to_fc", data_to_fc, 0);
      check("arst rx_ready", io_rx_ready, 1);
      io_tx_ready = 1'b0;
      step();
      rst = 1'b1;
      acc(0, 32'h0001_0, 8'h00);
      check("ram kept", data_to_fc, 8'hA5);
      acc(0, 32'h3_0004, 8'h00);
      check("status after rst", data_to_fc, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
